rv32m_divider: RTL and testbench
================================

# rv32m_divider

Iterative 32-bit divider for the RV32M accelerator. It executes DIV, DIVU, REM and REMU and is the inverse-operation companion to the multiplier datapath. It uses a radix-2 restoring algorithm and retires one quotient bit per cycle. A start/busy/done handshake connects it to the same issue logic that drives the multiplier.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is supported; the special-case constants are defined for 32 bits.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; accepted only while busy_o=0.
- signed_i  in  1  1 selects DIV/REM, 0 selects DIVU/REMU; sampled on the accept edge.
- rem_i  in  1  1 returns the remainder, 0 returns the quotient; sampled on the accept edge.
- op_A_i  in  32  dividend; sampled on the accept edge.
- op_B_i  in  32  divisor; sampled on the accept edge.
- busy_o  out  1  high while state is not IDLE.
- done_o  out  1  one-cycle registered pulse; result_o is valid from this cycle.
- result_o  out  32  quotient or remainder; held until the next completion.

## Operation
- States:
  - IDLE.
  - ITER: 32 cycles, counter 0..31.
  - FIX: 1 cycle.
- IDLE to ITER: start_i=1, no special case, no cache hit. On the accept edge:
  - Load |A| into the dividend shift register and |B| into the divisor register; for signed ops the magnitude is the two's complement, and INT_MIN maps to 0x80000000 unsigned.
  - Clear the 33-bit partial remainder and the counter.
  - Latch neg_q = signed_i & (A[31]^B[31]), neg_r = signed_i & A[31], and rem_i.
- IDLE to FIX directly: special case or cache hit; the prepared result is latched.
- ITER step (sub-module):
  - rs = {rem[31:0], dvd[31]}; diff = rs - {1'b0, dvs}.
  - If diff[32]=0: rem=diff and qbit=1; otherwise rem=rs and qbit=0.
  - dvd shifts left with qbit inserted at bit 0, so dvd becomes the quotient.
  - counter==31 moves to FIX.
- FIX:
  - Quotient = neg_q ? -dvd : dvd; remainder = neg_r ? -rem[31:0] : rem[31:0].
  - Select the result by rem_i, load result_o, set done_o=1 for one cycle, return to IDLE.
- Special cases are resolved in IDLE and never iterate:
  - Divisor 0: quotient 0xFFFFFFFF and remainder = A, for both signed and unsigned.
  - signed_i=1, A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000, remainder 0.
- start_i while busy_o=1 is ignored, with no queueing.
- start_i in the cycle done_o is high is accepted, because the state is IDLE.
- rst_ni low at any time, including mid-ITER:
  - Immediately returns to IDLE.
  - Clears every register and the cache valid bit.
  - No done_o pulse occurs.

## Timing
- Reset values: busy_o=0, done_o=0, result_o=0.
- Accept edge E0. busy_o rises after E0.
- Normal op: ITER on E1..E32; FIX edge E33 loads result_o and done_o. done_o is high in the cycle after E33, and busy_o falls in that same cycle. Latency is 33 cycles.
- Special case or cache hit: result_o and done_o are loaded at E1. Latency is 1 cycle.
- Back-to-back: next start_i is accepted in the done_o cycle. Throughput is 1 normal op per 34 cycles.

## Configuration
- RV32M_DIV_CACHE_EN defined:
  - Store the last completed A, B, signed_i, quotient and remainder, plus a valid bit. Special-case results are stored too.
  - A start whose A, B and signed_i match with valid=1 completes in 1 cycle, selecting by rem_i. This covers DIV followed by REM fusion.
  - valid is cleared by reset.
- Undefined: no cache storage; every non-special op takes 33 cycles.

## Structure
- Shared package/include holds:
  - state encodings: IDLE, ITER, FIX.
  - DIV_ZERO_Q = 32'hFFFFFFFF.
  - INT_MIN = 32'h80000000.
  - NEG_ONE = 32'hFFFFFFFF.
  - ITER_LAST = 5'd31.
- One sub-module: div_step. It is combinational and computes (rem, dvd, dvs) to (rem_next, dvd_next) for one restoring iteration. The top level holds the FSM, registers, sign fix, special-case logic and cache.

## Test plan
- DIVU 100/7 -> result 14, done_o exactly 33 cycles after accept; REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; REM 7/0xFFFFFFFE (7/-2) -> 1.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIVU 0x80000000/0 -> 0xFFFFFFFF; each with 1-cycle latency.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, 1-cycle latency; DIVU of the same operands -> 0 after 33 cycles.
- DIV 100/7 then REM 100/7 issued in the done_o cycle:
  - With RV32M_DIV_CACHE_EN: second done_o 1 cycle after accept, result 2.
  - Without it: second done_o after 33 cycles, result 2.
- Start DIVU 1000/3, pulse start_i again at cycle 5 with different operands, then drop rst_ni at cycle 10:
  - The cycle-5 start is ignored.
  - After reset: busy_o=0, result_o=0, no done_o.
  - A following DIVU 9/3 returns 3 in 33 cycles.

Source files
------------

// File: rtl/rv32m_divider_pkg.sv
// ----------------------------------------------------------------------------
// rv32m_divider_pkg
// Shared definitions for the RV32M iterative divider: FSM state encoding,
// special-case result constants, the last iteration index and small
// two's-complement helpers used when loading magnitudes and fixing signs.
// Optional feature macro used by the design: RV32M_DIV_CACHE_EN.
// ----------------------------------------------------------------------------
package rv32m_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    localparam logic [31:0] NEG_ONE    = 32'hFFFF_FFFF;
    localparam logic [4:0]  ITER_LAST  = 5'd31;

    // Two's-complement negation.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of an operand; unsigned ops pass through unchanged.
    // INT_MIN negates to itself, which read unsigned is the correct 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/rv32m_divider_if.sv
// ----------------------------------------------------------------------------
// rv32m_divider_if
// Start/busy/done handshake and operand/result bus between the issue logic
// (master) and the divider (slave).
//   start_i   request, accepted only while busy_o=0
//   signed_i  1: DIV/REM, 0: DIVU/REMU
//   rem_i     1: remainder, 0: quotient
//   op_A_i    dividend
//   op_B_i    divisor
//   busy_o    divider not idle
//   done_o    one-cycle completion pulse
//   result_o  quotient or remainder, held until the next completion
// ----------------------------------------------------------------------------
interface rv32m_divider_if;
    logic        start_i;
    logic        signed_i;
    logic        rem_i;
    logic [31:0] op_A_i;
    logic [31:0] op_B_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] result_o;

    modport master (
        output start_i, signed_i, rem_i, op_A_i, op_B_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, signed_i, rem_i, op_A_i, op_B_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/rv32m_divider_div_step.sv
// ----------------------------------------------------------------------------
// rv32m_divider_div_step
// One combinational radix-2 restoring division iteration.
//   i_rem       partial remainder (low 32 bits; it is always below the divisor)
//   i_dvd       dividend shift register, becomes the quotient over 32 steps
//   i_dvs       divisor magnitude
//   o_rem_next  partial remainder after this step
//   o_dvd_next  dividend shifted left with the new quotient bit at bit 0
// ----------------------------------------------------------------------------
module rv32m_divider_div_step (
    input  logic [31:0] i_rem,
    input  logic [31:0] i_dvd,
    input  logic [31:0] i_dvs,
    output logic [31:0] o_rem_next,
    output logic [31:0] o_dvd_next
);

    logic [32:0] w_rs;
    logic [32:0] w_diff;
    logic        w_qbit;

    // Trial subtraction; keep the difference only when it did not go negative.
    always_comb begin
        w_rs   = {i_rem, i_dvd[31]};
        w_diff = w_rs - {1'b0, i_dvs};
        if (!w_diff[32]) begin
            // Non-negative difference is below the divisor, so it fits 32 bits.
            o_rem_next = w_diff[31:0];
            w_qbit     = 1'b1;
        end else begin
            // Restored value was below the divisor, so bit 32 is zero.
            o_rem_next = w_rs[31:0];
            w_qbit     = 1'b0;
        end
        o_dvd_next = {i_dvd[30:0], w_qbit};
    end

endmodule

// File: rtl/rv32m_divider.sv
// ----------------------------------------------------------------------------
// rv32m_divider
// Iterative 32-bit RV32M divider (DIV, DIVU, REM, REMU), radix-2 restoring,
// one quotient bit per cycle. Normal ops take 33 cycles (32 ITER + 1 FIX);
// divide-by-zero and signed overflow resolve in IDLE and finish in 1 cycle.
// Optional feature: RV32M_DIV_CACHE_EN keeps the last completed operands
// and both results so a matching follow-up (e.g. DIV then REM) takes 1 cycle.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   bus     rv32m_divider_if slave modport (handshake, operands, result)
// ----------------------------------------------------------------------------
module rv32m_divider
    import rv32m_divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    rv32m_divider_if.slave  bus
);

    div_state_e      r_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_rem;     // partial remainder; bit 32 is never set
    logic [XLEN-1:0] r_dvd;
    logic [XLEN-1:0] r_dvs;
    logic            r_neg_q;
    logic            r_neg_r;
    logic            r_rem_sel;
    logic            r_bypass;  // FIX uses the prepared result, not the iteration
    logic [XLEN-1:0] r_pre_q;
    logic [XLEN-1:0] r_pre_r;
    logic [XLEN-1:0] r_result;
    logic            r_done;
    logic            r_busy;

`ifdef RV32M_DIV_CACHE_EN
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic            r_sgn;
    logic            r_c_valid;
    logic [XLEN-1:0] r_c_a;
    logic [XLEN-1:0] r_c_b;
    logic            r_c_sgn;
    logic [XLEN-1:0] r_c_q;
    logic [XLEN-1:0] r_c_r;
`endif

    logic            w_div_zero;
    logic            w_ovf;
    logic            w_hit;
    logic            w_fast;
    logic [XLEN-1:0] w_pre_q;
    logic [XLEN-1:0] w_pre_r;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_dvd_next;
    logic [XLEN-1:0] w_q_final;
    logic [XLEN-1:0] w_r_final;

    rv32m_divider_div_step u_step (
        .i_rem      (r_rem),
        .i_dvd      (r_dvd),
        .i_dvs      (r_dvs),
        .o_rem_next (w_rem_next),
        .o_dvd_next (w_dvd_next)
    );

    // Detect single-cycle requests and prepare their quotient/remainder pair.
    always_comb begin
        w_div_zero = (bus.op_B_i == 32'd0);
        w_ovf      = bus.signed_i && (bus.op_A_i == INT_MIN) && (bus.op_B_i == NEG_ONE);
`ifdef RV32M_DIV_CACHE_EN
        w_hit = r_c_valid && (bus.op_A_i == r_c_a) && (bus.op_B_i == r_c_b)
                && (bus.signed_i == r_c_sgn);
`else
        w_hit = 1'b0;
`endif
        w_fast = w_div_zero || w_ovf || w_hit;
        if (w_div_zero) begin
            w_pre_q = DIV_ZERO_Q;
            w_pre_r = bus.op_A_i;
        end else if (w_ovf) begin
            w_pre_q = INT_MIN;
            w_pre_r = 32'd0;
        end else begin
`ifdef RV32M_DIV_CACHE_EN
            w_pre_q = r_c_q;
            w_pre_r = r_c_r;
`else
            w_pre_q = 32'd0;
            w_pre_r = 32'd0;
`endif
        end
    end

    // Final signed quotient and remainder seen during FIX.
    always_comb begin
        if (r_bypass) begin
            w_q_final = r_pre_q;
            w_r_final = r_pre_r;
        end else begin
            w_q_final = r_neg_q ? neg32(r_dvd) : r_dvd;
            w_r_final = r_neg_r ? neg32(r_rem) : r_rem;
        end
    end

    // Divider FSM with all datapath registers and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 5'd0;
            r_rem     <= 32'd0;
            r_dvd     <= 32'd0;
            r_dvs     <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem_sel <= 1'b0;
            r_bypass  <= 1'b0;
            r_pre_q   <= 32'd0;
            r_pre_r   <= 32'd0;
            r_result  <= 32'd0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef RV32M_DIV_CACHE_EN
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_sgn     <= 1'b0;
            r_c_valid <= 1'b0;
            r_c_a     <= 32'd0;
            r_c_b     <= 32'd0;
            r_c_sgn   <= 1'b0;
            r_c_q     <= 32'd0;
            r_c_r     <= 32'd0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_i) begin
                        r_busy    <= 1'b1;
                        r_rem_sel <= bus.rem_i;
`ifdef RV32M_DIV_CACHE_EN
                        r_a       <= bus.op_A_i;
                        r_b       <= bus.op_B_i;
                        r_sgn     <= bus.signed_i;
`endif
                        if (w_fast) begin
                            r_bypass <= 1'b1;
                            r_pre_q  <= w_pre_q;
                            r_pre_r  <= w_pre_r;
                            r_state  <= ST_FIX;
                        end else begin
                            r_bypass <= 1'b0;
                            r_dvd    <= mag32(bus.op_A_i, bus.signed_i);
                            r_dvs    <= mag32(bus.op_B_i, bus.signed_i);
                            r_rem    <= 32'd0;
                            r_cnt    <= 5'd0;
                            r_neg_q  <= bus.signed_i && (bus.op_A_i[31] ^ bus.op_B_i[31]);
                            r_neg_r  <= bus.signed_i && bus.op_A_i[31];
                            r_state  <= ST_ITER;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_ITER: begin
                    r_done <= 1'b0;
                    r_rem  <= w_rem_next;
                    r_dvd  <= w_dvd_next;
                    r_cnt  <= r_cnt + 5'd1;
                    if (r_cnt == ITER_LAST) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_state <= ST_ITER;
                    end
                end
                ST_FIX: begin
                    r_result <= r_rem_sel ? w_r_final : w_q_final;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
`ifdef RV32M_DIV_CACHE_EN
                    r_c_valid <= 1'b1;
                    r_c_a     <= r_a;
                    r_c_b     <= r_b;
                    r_c_sgn   <= r_sgn;
                    r_c_q     <= w_q_final;
                    r_c_r     <= w_r_final;
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = r_busy;
    assign bus.done_o   = r_done;
    assign bus.result_o = r_result;

endmodule

// File: tb/tb_rv32m_divider.sv
// ----------------------------------------------------------------------------
// tb_rv32m_divider
// Directed, table-driven bench for rv32m_divider. Expected results are hand
// computed; expected latency comes from a tiny model of the special cases
// and (when RV32M_DIV_CACHE_EN is defined) of the last-result cache.
// ----------------------------------------------------------------------------
module tb_rv32m_divider;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32m_divider_if bus_if ();

    rv32m_divider #(.XLEN(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_if)
    );

`ifdef RV32M_DIV_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    // Latency model state: last completed operation.
    bit          m_valid = 1'b0;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_sgn;

    typedef struct {
        string       name;
        logic        sgn;
        logic        rem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[18];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        bit special;
        bit hit;
        special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = CACHE_EN && m_valid && (a == m_a) && (b == m_b) && (sgn == m_sgn);
        return (special || hit) ? 1 : 33;
    endfunction

    function automatic void model_done(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        m_valid = 1'b1;
        m_a     = a;
        m_b     = b;
        m_sgn   = sgn;
    endfunction

    task automatic set_vec(input int i, input string name, input logic sgn, input logic rem,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        vecs[i].name = name;
        vecs[i].sgn  = sgn;
        vecs[i].rem  = rem;
        vecs[i].a    = a;
        vecs[i].b    = b;
        vecs[i].exp  = exp;
    endtask

    // Drive a request for one rising edge (the accept edge) then drop start.
    task automatic start_op(input logic sgn, input logic rem, input logic [31:0] a, input logic [31:0] b);
        bus_if.signed_i = sgn;
        bus_if.rem_i    = rem;
        bus_if.op_A_i   = a;
        bus_if.op_B_i   = b;
        bus_if.start_i  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start_i  = 1'b0;
    endtask

    // Count edges after the accept edge until done_o; lat=0 means timed out.
    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = 0;
        res = 32'd0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done_o) begin
                lat = i;
                res = bus_if.result_o;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic sgn, input logic rem,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        int          lat;
        int          exp_lat;
        logic [31:0] res;
        exp_lat = model_lat(sgn, a, b);
        start_op(sgn, rem, a, b);
        check32({name, "_busy"}, 32'(bus_if.busy_o), 32'd1);
        wait_done(lat, res);
        check32({name, "_res"}, res, exp);
        check32({name, "_lat"}, 32'(lat), 32'(exp_lat));
        model_done(sgn, a, b);
    endtask

    initial begin
        int          lat;
        int          done_seen;
        logic [31:0] res;

        bus_if.start_i  = 1'b0;
        bus_if.signed_i = 1'b0;
        bus_if.rem_i    = 1'b0;
        bus_if.op_A_i   = 32'd0;
        bus_if.op_B_i   = 32'd0;

        set_vec(0,  "divu_100_7",     1'b0, 1'b0, 32'd100,        32'd7,          32'd14);
        set_vec(1,  "remu_100_7",     1'b0, 1'b1, 32'd100,        32'd7,          32'd2);
        set_vec(2,  "div_m7_2",       1'b1, 1'b0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
        set_vec(3,  "rem_m7_2",       1'b1, 1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
        set_vec(4,  "rem_7_m2",       1'b1, 1'b1, 32'd7,          32'hFFFF_FFFE,  32'd1);
        set_vec(5,  "div_7_m2",       1'b1, 1'b0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD);
        set_vec(6,  "div_5_0",        1'b1, 1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF);
        set_vec(7,  "rem_5_0",        1'b1, 1'b1, 32'd5,          32'd0,          32'd5);
        set_vec(8,  "divu_min_0",     1'b0, 1'b0, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF);
        set_vec(9,  "div_ovf",        1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
        set_vec(10, "rem_ovf",        1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        set_vec(11, "divu_ovf_ops",   1'b0, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);
        set_vec(12, "divu_max_1",     1'b0, 1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF);
        set_vec(13, "remu_max_16",    1'b0, 1'b1, 32'hFFFF_FFFF,  32'd16,         32'd15);
        set_vec(14, "div_min_2",      1'b1, 1'b0, 32'h8000_0000,  32'd2,          32'hC000_0000);
        set_vec(15, "rem_m7_0",       1'b1, 1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);
        set_vec(16, "divu_0_5",       1'b0, 1'b0, 32'd0,          32'd5,          32'd0);
        set_vec(17, "rem_min_min",    1'b1, 1'b1, 32'h8000_0000,  32'h8000_0000,  32'd0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check32("rst_busy",   32'(bus_if.busy_o), 32'd0);
        check32("rst_done",   32'(bus_if.done_o), 32'd0);
        check32("rst_result", bus_if.result_o,    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of directed vectors
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].rem, vecs[i].a, vecs[i].b, vecs[i].exp);
            if (i == 0) begin
                // done_o is a single-cycle pulse and busy_o is already low
                @(posedge clk);
                #1;
                check32("done_pulse_width", 32'(bus_if.done_o), 32'd0);
                check32("busy_after_done",  32'(bus_if.busy_o), 32'd0);
                check32("result_held",      bus_if.result_o,    32'd14);
            end
        end

        // DIV 100/7 then REM 100/7 issued in the done_o cycle
        @(negedge clk);
        run_op("b2b_div", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14);
        run_op("b2b_rem", 1'b1, 1'b1, 32'd100, 32'd7, 32'd2);

        // A start while busy is ignored; the first op completes unchanged
        @(negedge clk);
        start_op(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus_if.op_A_i  = 32'd50;
        bus_if.op_B_i  = 32'd5;
        bus_if.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b0;
        lat = 0;
        res = 32'd0;
        for (int i = 6; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done_o) begin
                lat = i;
                res = bus_if.result_o;
                break;
            end
        end
        check32("busy_ignore_res", res, 32'd333);
        check32("busy_ignore_lat", 32'(lat), 32'd33);
        model_done(1'b0, 32'd1000, 32'd3);

        // Reset mid-ITER: start at cycle 0, extra start at cycle 5, reset at cycle 10
        @(negedge clk);
        start_op(1'b0, 1'b0, 32'd1000, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus_if.op_A_i  = 32'd77;
        bus_if.op_B_i  = 32'd11;
        bus_if.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b0;
        m_valid = 1'b0;
        #1;
        check32("midrst_busy",   32'(bus_if.busy_o), 32'd0);
        check32("midrst_result", bus_if.result_o,    32'd0);
        check32("midrst_done",   32'(bus_if.done_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done_o) done_seen++;
        end
        check32("midrst_no_done", 32'(done_seen), 32'd0);
        check32("midrst_idle",    32'(bus_if.busy_o), 32'd0);
        @(negedge clk);
        run_op("post_rst_divu_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
